serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: diff = a - b - bin, processed LSB-first at one bit/clock.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor_gate.sv | 30 +++
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
//   sub_state_t : controller states (IDLE accepts operands, SHIFT runs one bit per clock,
//                 HOLD presents the result until the consumer takes it).
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor_gate.sv
// One-bit full subtractor built from gate primitives.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit, a ^ b ^ bin
//   bout : borrow out, (~a & b) | (~a & bin) | (b & bin)
module full_subtractor_gate (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic ab_x;
  logic a_n;
  logic p_nab;
  logic p_nabin;
  logic p_bbin;

  xor u_x0 (ab_x, a, b);
  xor u_x1 (d, ab_x, bin);

  not u_n0 (a_n, a);
  and u_a0 (p_nab, a_n, b);
  and u_a1 (p_nabin, a_n, bin);
  and u_a2 (p_bbin, b, bin);
  or  u_o0 (bout, p_nab, p_nabin, p_bbin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
//   clk, rst            : clock (rising edge) and asynchronous active-high reset
//   in_valid / in_ready : operand handshake; operands sampled only on accept
//   a, b, bin           : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake; result held stable until taken
//   diff                : a - b - bin mod 2^WIDTH (0 outside HOLD)
//   bout                : borrow out (unsigned a < b + bin), 0 outside HOLD
//   ovf                 : signed overflow, 0 outside HOLD
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] diff_sr_q;
  logic [CntW-1:0]  cnt_q;
  logic             borrow_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic accept;
  logic fs_d;
  logic fs_bout;

  assign accept = in_valid & in_ready;

  full_subtractor_gate u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CntLast) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: results are exposed only in HOLD so a partial shift is never visible.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    diff      = '0;
    bout      = 1'b0;
    ovf       = 1'b0;
    unique case (state_q)
      IDLE: in_ready = ~rst;
      HOLD: begin
        out_valid = 1'b1;
        diff      = diff_sr_q;
        bout      = borrow_q;
        // Operands of differing sign whose result sign differs from the minuend's.
        ovf       = (a_msb_q ^ b_msb_q) & (diff_sr_q[WIDTH-1] ^ a_msb_q);
      end
      default: ;
    endcase
  end

  // Datapath: operand/result shift registers, borrow FF, bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            borrow_q <= bin;
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
            cnt_q    <= '0;
          end
        end
        SHIFT: begin
          diff_sr_q <= {fs_d, diff_sr_q[WIDTH-1:1]};
          a_sr_q    <= a_sr_q >> 1;
          b_sr_q    <= b_sr_q >> 1;
          borrow_q  <= fs_bout;
          // Saturate rather than wrap on the final bit
          if (cnt_q != CntLast) cnt_q <= cnt_q + CntW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the specification's definition.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
    int unsigned full;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    full = (int'(ra) - int'(rb) - int'(rbin) + (1 << W)) % (1 << W);
    d    = W'(full);
    br   = (int'(ra) < int'(rb) + int'(rbin));
    ov   = (ra[W-1] != rb[W-1]) && (d[W-1] != ra[W-1]);
    return {ov, br, d};
  endfunction

  // Drives one operation: accept, count latency, stall in HOLD, then handshake.
  // Returns the values observed in HOLD; comparisons are done by the caller.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input int stall, output logic [W-1:0] od, output logic obo,
                        output logic oov, output int lat, output bit tmo);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operand changes after accept must have no effect
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    tmo = !out_valid;
    repeat (stall) tick();
    od = diff; obo = bout; oov = ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
    end
    n_cmp++;
    if (diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: diff=%h bout=%b ovf=%b, required 00/0/0", diff, bout, ovf);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vbin [4];
    logic [W-1:0] d;
    logic         bo, ov;
    logic [W+1:0] e;
    int           lat;
    bit           tmo;
    va[0] = 8'h5A; vb[0] = 8'h3C; vbin[0] = 1'b0;
    va[1] = 8'h00; vb[1] = 8'h01; vbin[1] = 1'b0;
    va[2] = 8'h80; vb[2] = 8'h01; vbin[2] = 1'b0;
    va[3] = 8'h10; vb[3] = 8'h0F; vbin[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vbin[i], 0, d, bo, ov, lat, tmo);
      e = ref_sub(va[i], vb[i], vbin[i]);
      n_cmp++;
      if (tmo || lat != W) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: %0d cycles (timeout=%0b), required %0d", i, lat, tmo, W);
      end
      n_cmp++;
      if ({ov, bo, d} !== e) begin
        n_err++;
        $display("FAIL dir_result[%0d]: diff=%h bout=%b ovf=%b, required diff=%h bout=%b ovf=%b",
                 i, d, bo, ov, e[W-1:0], e[W], e[W+1]);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir_ack[%0d]: out_valid=%b after handshake, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_hold_stall();
    logic [W+1:0] e;
    int n;
    e = ref_sub(8'hC3, 8'h47, 1'b1);
    while (!in_ready) tick();
    a = 8'hC3; b = 8'h47; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, bout, diff} !== e) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: ov=%b rdy=%b diff=%h bout=%b ovf=%b, required 1/0 %h/%b/%b",
                 i, out_valid, in_ready, diff, bout, ovf, e[W-1:0], e[W], e[W+1]);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_ack: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    logic         bo, ov;
    int           lat;
    bit           tmo;
    while (!in_ready) tick();
    a = 8'h77; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || diff !== '0) begin
      n_err++;
      $display("FAIL midrst: out_valid=%b in_ready=%b diff=%h, required 0/0/00",
               out_valid, in_ready, diff);
    end
    tick();
    rst = 1'b0;
    #1;
    run_op(8'h03, 8'h05, 1'b0, 1, d, bo, ov, lat, tmo);
    n_cmp++;
    if (tmo || d !== 8'hFE || bo !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_next: diff=%h bout=%b timeout=%0b, required diff=fe bout=1",
               d, bo, tmo);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, d;
    logic         rbin, bo, ov;
    logic [W+1:0] e;
    int           lat;
    bit           tmo;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      run_op(ra, rb, rbin, int'($urandom_range(0, 3)), d, bo, ov, lat, tmo);
      e = ref_sub(ra, rb, rbin);
      n_cmp++;
      if (tmo || {ov, bo, d} !== e) begin
        n_err++;
        $display("FAIL rand[%0d] %h-%h-%b: diff=%h bout=%b ovf=%b tmo=%0b, required %h/%b/%b",
                 i, ra, rb, rbin, d, bo, ov, tmo, e[W-1:0], e[W], e[W+1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
